// File: rtl/entrada_fifo_if.sv
// Keyboard/CPU read bus between the PS/2 decoder, the CPU input path and the keycode FIFO.
// The master drives keycodes and read selects; the slave returns the keycode and status flags.
interface entrada_fifo_if;
    logic [7:0] KeyData;
    logic       KeyValid;
    logic [1:0] In;
    logic [7:0] resultadoKeyBoard;
    logic       KeyEmpty;
    logic       KeyOverflow;

    modport master (
        output KeyData, KeyValid, In,
        input  resultadoKeyBoard, KeyEmpty, KeyOverflow
    );

    modport slave (
        input  KeyData, KeyValid, In,
        output resultadoKeyBoard, KeyEmpty, KeyOverflow
    );
endinterface

// File: rtl/entrada_fifo.sv
// Processor input unit: switch capture, debounced push-button, run/step/halt CPU clock
// generator and a PS/2 keycode FIFO so no keypress is lost between CPU reads.
module entrada_fifo #(
    parameter int SW_WIDTH   = 14,
    parameter int DEB_BITS   = 6,
    parameter int DIV_RUN    = 1562500,
    parameter int STEP_HIGH  = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_BITS   = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Botao,
    input  logic [SW_WIDTH-1:0] Sw,
    input  logic [1:0]          Mode,
    entrada_fifo_if.slave       key_bus,
    output logic [SW_WIDTH-1:0] resultadoEntrada,
    output logic                saidaBotao,
    output logic                saidaClock
);

    localparam int DIV_W  = (DIV_RUN > 0) ? $clog2(DIV_RUN + 1) : 1;
    localparam int STEP_W = (STEP_HIGH > 1) ? $clog2(STEP_HIGH) : 1;
    localparam logic [DIV_W-1:0]  DIV_TC      = DIV_W'(DIV_RUN);
    localparam logic [STEP_W-1:0] STEP_LOAD   = STEP_W'(STEP_HIGH - 1);
    localparam logic [PTR_BITS:0] CNT_FULL    = (PTR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [1:0]        IN_KEY_READ = 2'b10;

    typedef enum logic [1:0] {
        CLK_RUN  = 2'b00,
        CLK_STEP = 2'b01,
        CLK_HALT = 2'b10
    } clk_state_e;

    // Debouncer and press-event detector
    logic [DEB_BITS-1:0] deb_cnt_q, deb_cnt_d;
    logic                btn_q, btn_d;
    logic                press;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path leaves it unassigned and infers a latch.
        deb_cnt_d = deb_cnt_q;
        if (Botao) begin
            deb_cnt_d = '0;
        end else if (!deb_cnt_q[DEB_BITS-1]) begin
            deb_cnt_d = deb_cnt_q + DEB_BITS'(1);
        end
        btn_d = deb_cnt_q[DEB_BITS-1];
        press = deb_cnt_q[DEB_BITS-1] & ~btn_q;
    end

    // Switch capture: the MSB switch enables the load and reads back as zero
    logic [SW_WIDTH-1:0] sw_q, sw_d;

    always_comb begin
        sw_d = sw_q;
        if (Sw[SW_WIDTH-1]) begin
            sw_d = {1'b0, Sw[SW_WIDTH-2:0]};
        end
    end

    // CPU clock generator
    clk_state_e          state_q, state_d, mode_state;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                sclk_q, sclk_d;

    always_comb begin
        case (Mode)
            2'b00:   mode_state = CLK_RUN;
            2'b01:   mode_state = CLK_STEP;
            default: mode_state = CLK_HALT;
        endcase

        state_d = mode_state;
        div_d   = div_q;
        step_d  = step_q;
        sclk_d  = sclk_q;

        if (mode_state != state_q) begin
            // A mode change restarts both timers; a press landing on this cycle is dropped.
            div_d  = '0;
            step_d = '0;
            if (mode_state == CLK_STEP) begin
                sclk_d = 1'b0;
            end
        end else begin
            case (state_q)
                CLK_RUN: begin
                    if (div_q == DIV_TC) begin
                        div_d  = '0;
                        sclk_d = ~sclk_q;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                CLK_STEP: begin
                    if (sclk_q) begin
                        if (step_q == '0) begin
                            sclk_d = 1'b0;
                        end else begin
                            step_d = step_q - STEP_W'(1);
                        end
                    end else if (press) begin
                        sclk_d = 1'b1;
                        step_d = STEP_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Keycode FIFO
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   cnt_q, cnt_d;
    logic                rd_sel_q, rd_sel_d;
    logic [7:0]          kb_q, kb_d;
    logic                ovf_q, ovf_d;
    logic                rd_sel_now, rd_strobe, push_req;
    logic                fifo_empty, fifo_full, do_push, do_pop;

    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_FULL);
        rd_sel_now = (key_bus.In == IN_KEY_READ);
        rd_strobe  = rd_sel_now && !rd_sel_q;
        push_req   = key_bus.KeyValid && (key_bus.KeyData != 8'h00);
        do_pop     = rd_strobe && !fifo_empty;
        // A full FIFO still accepts a push when the same cycle pops a slot free.
        do_push    = push_req && (!fifo_full || do_pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rd_sel_d = rd_sel_now;
        ovf_d    = ovf_q | (push_req && !do_push);

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (PTR_BITS + 1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (PTR_BITS + 1)'(1);
        end

        if (rd_strobe) begin
            kb_d = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
        end else if (rd_sel_now) begin
            kb_d = kb_q;
        end else begin
            kb_d = 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            deb_cnt_q <= '0;
            btn_q     <= 1'b0;
            sw_q      <= '0;
            state_q   <= CLK_RUN;
            div_q     <= '0;
            step_q    <= '0;
            sclk_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_sel_q  <= 1'b0;
            kb_q      <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            btn_q     <= btn_d;
            sw_q      <= sw_d;
            state_q   <= state_d;
            div_q     <= div_d;
            step_q    <= step_d;
            sclk_q    <= sclk_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_sel_q  <= rd_sel_d;
            kb_q      <= kb_d;
            ovf_q     <= ovf_d;
        end
    end

    // NOTE: the storage array is not reset; pointers and count define which entries are valid, and this keeps it RAM-mappable.
    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= key_bus.KeyData;
        end
    end

    assign resultadoEntrada          = sw_q;
    assign saidaBotao                = deb_cnt_q[DEB_BITS-1];
    assign saidaClock                = sclk_q;
    assign key_bus.resultadoKeyBoard = kb_q;
    assign key_bus.KeyEmpty          = fifo_empty;
    assign key_bus.KeyOverflow       = ovf_q;

endmodule

// File: tb/tb_entrada_fifo.sv
// Self-checking bench for entrada_fifo: directed steps plus a randomized phase, all outputs
// compared every cycle against a queue/arithmetic reference model.
module tb_entrada_fifo;

    localparam int SW_WIDTH   = 14;
    localparam int DEB_BITS   = 6;
    localparam int DIV_RUN    = 4;
    localparam int STEP_HIGH  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_BITS   = 3;
    localparam int DEB_LIMIT  = 1 << (DEB_BITS - 1);

    logic                clk = 1'b0;
    logic                Reset;
    logic                Botao;
    logic [SW_WIDTH-1:0] Sw;
    logic [1:0]          Mode;
    logic [SW_WIDTH-1:0] resultadoEntrada;
    logic                saidaBotao;
    logic                saidaClock;

    entrada_fifo_if kb ();

    entrada_fifo #(
        .SW_WIDTH  (SW_WIDTH),
        .DEB_BITS  (DEB_BITS),
        .DIV_RUN   (DIV_RUN),
        .STEP_HIGH (STEP_HIGH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PTR_BITS  (PTR_BITS)
    ) dut (
        .Clock           (clk),
        .Reset           (Reset),
        .Botao           (Botao),
        .Sw              (Sw),
        .Mode            (Mode),
        .key_bus         (kb),
        .resultadoEntrada(resultadoEntrada),
        .saidaBotao      (saidaBotao),
        .saidaClock      (saidaClock)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]          q[$];
    logic [7:0]          exp_kb;
    logic                exp_ovf;
    logic                prev_rd;
    logic [SW_WIDTH-1:0] exp_sw;
    int                  low_n;
    logic                exp_deb;
    logic                press_pend;
    logic                exp_clk;
    int                  m_mode;
    int                  run_k;
    logic                run_base;
    int                  hi_left;

    // Observed-output bookkeeping
    int   btn_rises, clk_rises, clk_high;
    logic obs_btn_prev, obs_clk_prev;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_kb     = 8'h00;
        exp_ovf    = 1'b0;
        prev_rd    = 1'b0;
        exp_sw     = '0;
        low_n      = 0;
        exp_deb    = 1'b0;
        press_pend = 1'b0;
        exp_clk    = 1'b0;
        m_mode     = -1;
        run_k      = 0;
        run_base   = 1'b0;
        hi_left    = 0;
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic model_step();
        int   tgt;
        logic strobe, push_req, full, popped, deb_new;
        popped = 1'b0;

        tgt = (Mode == 2'b00) ? 0 : (Mode == 2'b01) ? 1 : 2;
        if (tgt != m_mode) begin
            m_mode   = tgt;
            run_k    = 0;
            run_base = exp_clk;
            hi_left  = 0;
            if (tgt == 1) exp_clk = 1'b0;
        end else if (tgt == 0) begin
            run_k++;
            exp_clk = run_base ^ (((run_k / (DIV_RUN + 1)) % 2) == 1);
        end else if (tgt == 1) begin
            if (exp_clk) begin
                hi_left--;
                if (hi_left == 0) exp_clk = 1'b0;
            end else if (press_pend) begin
                exp_clk = 1'b1;
                hi_left = STEP_HIGH;
            end
        end

        low_n      = Botao ? 0 : ((low_n < DEB_LIMIT) ? low_n + 1 : low_n);
        deb_new    = (low_n >= DEB_LIMIT);
        press_pend = deb_new && !exp_deb;
        exp_deb    = deb_new;

        if (Sw[SW_WIDTH-1]) exp_sw = {1'b0, Sw[SW_WIDTH-2:0]};

        strobe   = (kb.In == 2'b10) && !prev_rd;
        push_req = kb.KeyValid && (kb.KeyData != 8'h00);
        full     = (q.size() == FIFO_DEPTH);
        if (strobe) begin
            popped = (q.size() > 0);
            exp_kb = popped ? q.pop_front() : 8'h00;
        end else if (kb.In != 2'b10) begin
            exp_kb = 8'h00;
        end
        if (push_req) begin
            if (!full || popped) q.push_back(kb.KeyData);
            else exp_ovf = 1'b1;
        end
        prev_rd = (kb.In == 2'b10);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (Reset) model_reset();
        else model_step();
        check("saidaBotao", saidaBotao, exp_deb);
        check("saidaClock", saidaClock, exp_clk);
        check("resultadoEntrada", resultadoEntrada, exp_sw);
        check("resultadoKeyBoard", kb.resultadoKeyBoard, exp_kb);
        check("KeyEmpty", kb.KeyEmpty, q.size() == 0);
        check("KeyOverflow", kb.KeyOverflow, exp_ovf);
        if (saidaBotao && !obs_btn_prev) btn_rises++;
        if (saidaClock && !obs_clk_prev) clk_rises++;
        if (saidaClock) clk_high++;
        obs_btn_prev = saidaBotao;
        obs_clk_prev = saidaClock;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Botao = 1'b1;
        Sw    = '0;
        Mode  = 2'b10;
        kb.KeyData  = 8'h00;
        kb.KeyValid = 1'b0;
        kb.In       = 2'b00;
        model_reset();
        btn_rises = 0; clk_rises = 0; clk_high = 0;
        obs_btn_prev = 1'b0; obs_clk_prev = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_keyempty", kb.KeyEmpty, 1);
        check("reset_keyboard", kb.resultadoKeyBoard, 8'h00);
        check("reset_overflow", kb.KeyOverflow, 0);
        check("reset_saidaclock", saidaClock, 0);
        Reset = 1'b0;

        // Switch capture
        Sw = 14'h2ABC;
        tick();
        check("sw_capture", resultadoEntrada, 14'h0ABC);
        Sw = 14'h1555;
        repeat (3) tick();
        check("sw_hold", resultadoEntrada, 14'h0ABC);
        Sw = 14'h3FFF;
        tick();
        check("sw_msb_masked", resultadoEntrada, 14'h1FFF);
        Sw = '0;
        tick();

        // Debouncer: a short press never qualifies, a long one gives exactly one event
        btn_rises = 0;
        Botao = 1'b0;
        repeat (20) tick();
        check("deb_short_press", saidaBotao, 0);
        Botao = 1'b1;
        tick();
        Botao = 1'b0;
        repeat (DEB_LIMIT - 1) tick();
        check("deb_one_short", saidaBotao, 0);
        tick();
        check("deb_threshold", saidaBotao, 1);
        repeat (8) tick();
        check("deb_press_count", btn_rises, 1);
        Botao = 1'b1;
        tick();
        check("deb_release", saidaBotao, 0);

        // Run mode, then halt freezes the clock
        Mode = 2'b00;
        tick();
        check("run_enter", saidaClock, 0);
        clk_rises = 0;
        repeat (27) tick();
        check("run_phase", saidaClock, 1);
        check("run_rises", clk_rises, 3);
        Mode = 2'b10;
        clk_high = 0;
        repeat (10) tick();
        check("halt_frozen", clk_high, 10);

        // Step mode: three presses, three STEP_HIGH-cycle pulses
        Mode = 2'b01;
        tick();
        check("step_enter_low", saidaClock, 0);
        clk_rises = 0;
        clk_high  = 0;
        repeat (3) begin
            Botao = 1'b0;
            repeat (40) tick();
            Botao = 1'b1;
            repeat (6) tick();
        end
        check("step_rises", clk_rises, 3);
        check("step_high_cycles", clk_high, 3 * STEP_HIGH);
        Mode = 2'b10;
        tick();

        // FIFO: zero code discarded, one pop per read access, zero between reads
        kb.KeyValid = 1'b1;
        kb.KeyData  = 8'h1C; tick();
        kb.KeyData  = 8'h32; tick();
        kb.KeyData  = 8'h00; tick();
        kb.KeyValid = 1'b0;
        tick();
        check("fifo_not_empty", kb.KeyEmpty, 0);
        kb.In = 2'b10;
        tick();
        check("read_first", kb.resultadoKeyBoard, 8'h1C);
        repeat (4) tick();
        check("read_first_held", kb.resultadoKeyBoard, 8'h1C);
        kb.In = 2'b00;
        tick();
        check("between_reads", kb.resultadoKeyBoard, 8'h00);
        tick();
        kb.In = 2'b10;
        tick();
        check("read_second", kb.resultadoKeyBoard, 8'h32);
        kb.In = 2'b00;
        tick();
        check("drained_zero", kb.resultadoKeyBoard, 8'h00);
        check("drained_empty", kb.KeyEmpty, 1);

        // FIFO overflow and push+pop on a full FIFO
        kb.KeyValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            kb.KeyData = 8'(8'h10 + i);
            tick();
            if (i == 7) check("ovf_at_full", kb.KeyOverflow, 0);
        end
        check("ovf_set", kb.KeyOverflow, 1);
        kb.KeyData = 8'h77;
        kb.In      = 2'b10;
        tick();
        check("full_push_pop_read", kb.resultadoKeyBoard, 8'h10);
        kb.KeyValid = 1'b0;
        kb.In       = 2'b00;
        tick();
        for (int i = 1; i <= 8; i++) begin
            kb.In = 2'b10;
            tick();
            check("drain_full", kb.resultadoKeyBoard, (i < 8) ? 8'(8'h10 + i) : 8'h77);
            kb.In = 2'b00;
            tick();
        end
        check("drain_full_empty", kb.KeyEmpty, 1);
        kb.In = 2'b10;
        tick();
        check("read_empty_zero", kb.resultadoKeyBoard, 8'h00);
        kb.In = 2'b00;
        tick();
        check("ovf_sticky", kb.KeyOverflow, 1);

        // Empty FIFO with push and read strobe together
        do_reset();
        check("ovf_cleared", kb.KeyOverflow, 0);
        kb.KeyValid = 1'b1;
        kb.KeyData  = 8'h5A;
        kb.In       = 2'b10;
        tick();
        check("empty_push_pop_read", kb.resultadoKeyBoard, 8'h00);
        check("empty_push_pop_stored", kb.KeyEmpty, 0);
        kb.KeyValid = 1'b0;
        kb.In       = 2'b00;
        tick();
        kb.In = 2'b10;
        tick();
        check("read_5a", kb.resultadoKeyBoard, 8'h5A);
        kb.In = 2'b00;
        tick();

        // Randomized phase: heavy push traffic first, then read-dominated traffic
        for (int i = 0; i < 800; i++) begin
            kb.KeyValid = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            kb.KeyData  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, (i < 400) ? 3 : 1) == 0) kb.In = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) Sw = SW_WIDTH'($urandom);
            if ($urandom_range(0, 49) == 0) Botao = ~Botao;
            if ($urandom_range(0, 59) == 0) Mode = 2'($urandom_range(0, 3));
            tick();
        end

        // Reset in the middle of a step pulse
        Botao       = 1'b1;
        Mode        = 2'b10;
        kb.KeyValid = 1'b0;
        kb.In       = 2'b00;
        do_reset();
        kb.KeyValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            kb.KeyData = 8'(8'h40 + i);
            tick();
        end
        kb.KeyValid = 1'b0;
        check("pre_reset_ovf", kb.KeyOverflow, 1);
        Mode = 2'b01;
        tick();
        Botao = 1'b0;
        repeat (DEB_LIMIT + 2) tick();
        check("step_high_pre_reset", saidaClock, 1);
        Reset = 1'b1;
        tick();
        check("reset_mid_step_clock", saidaClock, 0);
        check("reset_mid_step_empty", kb.KeyEmpty, 1);
        check("reset_mid_step_ovf", kb.KeyOverflow, 0);
        Reset = 1'b0;
        Botao = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/entrada_fifo.md
Name: entrada_fifo

Overview:
- Parametrised successor to the processor input unit.
- Functions: switch capture, debounced push-button, CPU clock generator with run/step/halt modes, and PS/2 keycode FIFO.
- Keycodes are buffered instead of held in a single register, so no keypress is lost between CPU reads.
- Sits between board I/O (switches, button, PS/2 decoder) and the MIPS datapath input instruction path.

Parameters:
- SW_WIDTH, 14: switch bus width; MSB is the capture-enable switch.
- DEB_BITS, 6: debounce counter width; button is valid when counter MSB is set (2^(DEB_BITS-1) stable cycles).
- DIV_RUN, 1562500: run-mode half-period terminal count.
- STEP_HIGH, 1000: high time of saidaClock per step pulse, in cycles.
- FIFO_DEPTH, 8: keycode FIFO entries; must be a power of two.
- PTR_BITS, 3: log2(FIFO_DEPTH).

Ports:
- Clock, in, 1: system clock; all logic is on its rising edge.
- Reset, in, 1: synchronous, active-high reset.
- Botao, in, 1: raw push-button, active low.
- Sw, in, SW_WIDTH: board switches.
- Mode, in, 2: 00 run, 01 step, 10/11 halt.
- KeyData, in, 8: scan code from the PS/2 decoder.
- KeyValid, in, 1: one-cycle strobe, KeyData valid.
- In, in, 2: CPU input select; 2'b10 is a keyboard read.
- resultadoEntrada, out, SW_WIDTH: captured switch value.
- resultadoKeyBoard, out, 8: keycode returned to the CPU.
- KeyEmpty, out, 1: FIFO empty.
- KeyOverflow, out, 1: sticky flag, a push was dropped.
- saidaBotao, out, 1: debounced button level.
- saidaClock, out, 1: generated CPU clock.

Behaviour:
- Reset (synchronous, highest priority):
  - All counters and pointers 0; FIFO empty.
  - All outputs 0; KeyEmpty is 1.
- Debouncer:
  - Botao=1 clears the counter.
  - Botao=0 increments the counter until its MSB sets, then holds.
  - saidaBotao = counter MSB.
  - Press event = rising edge of saidaBotao, via a registered copy; exactly one cycle per press.
- Switch capture:
  - If Sw[SW_WIDTH-1]=1, resultadoEntrada <= {1'b0, Sw[SW_WIDTH-2:0]}; otherwise it holds.
  - Latency: 1 cycle.
- Clock generator, state tracks Mode:
  - RUN (00): divider counts 0..DIV_RUN. At DIV_RUN it returns to 0 and saidaClock toggles. Period = 2*(DIV_RUN+1) cycles.
  - STEP (01): a press event while saidaClock=0 sets saidaClock=1 and loads the step counter. saidaClock returns to 0 after STEP_HIGH cycles. Presses while high are ignored. Exactly one rising edge per press.
  - HALT (10/11): divider and saidaClock hold.
  - Any Mode change clears both the divider and the step counter.
  - Entering STEP forces saidaClock=0 on the next cycle.
- FIFO:
  - Push when KeyValid=1 and KeyData!=0; zero codes are discarded.
  - Read strobe = In becomes 2'b10 while it was not 2'b10 the previous cycle. This gives one pop per CPU access, however long In is held.
  - On the read strobe: resultadoKeyBoard <= head entry and pop, or 0 if empty.
  - While In stays 2'b10, resultadoKeyBoard holds.
  - When In != 2'b10, resultadoKeyBoard <= 0.
  - Full with push only: data dropped, KeyOverflow <= 1. KeyOverflow is cleared only by Reset.
  - Full with push and pop together: both succeed, count unchanged, no overflow.
  - Empty with push and pop together: read returns 0, the push is stored, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count has PTR_BITS+1 bits; KeyEmpty = (count==0), combinational from registers.
- Reset mid-operation: step pulse aborted, FIFO contents discarded, saidaClock low the next cycle.

Test Plan:
- Sw=14'h2ABC, then Sw[13]=0 with other bits changed -> resultadoEntrada=14'h0ABC after 1 cycle, then holds 14'h0ABC.
- Botao low 20 cycles, then high, then low 40 cycles (DEB_BITS=6) -> saidaBotao stays 0 the first time; rises after 32 low cycles the second time; exactly one press event.
- Mode=00, DIV_RUN=4 -> saidaClock toggles every 5 cycles. Switch to 10 -> frozen. Switch to 01 with 3 presses, STEP_HIGH=4 -> three 4-cycle high pulses, none during holds.
- Push 8'h1C, 8'h32, 8'h00; In=10 held 5 cycles, 0 for 2, 10 again -> 8'h00 is ignored; reads return 8'h1C then 8'h32; output is 0 between reads; KeyEmpty=1 after.
- FIFO_DEPTH=8: push 9 codes -> 9th dropped, KeyOverflow=1. Next push coincident with a read strobe -> both succeed, count stays 8.
- Empty FIFO, KeyValid (8'h5A) coincident with the read strobe -> returns 0, KeyEmpty falls. Reset asserted mid step pulse -> saidaClock=0, KeyEmpty=1, KeyOverflow=0.
